// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: byte-wide transmit FIFO accepting up to WORD_BYTES bytes per push, popping one byte per handshake
module tx_byte_fifo #(
  parameter int ADDR_W = 10,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    push_valid,
  input  logic [CNT_W-1:0]        push_nbytes,
  input  logic [8*WORD_BYTES-1:0] push_data,
  output logic                    push_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic [ADDR_W:0]         level,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] free;
  logic clr, push_bad, push_ok, pop;
  assign clr = !rstn || flush;
  assign free = (ADDR_W+1)'(DEPTH) - level;
  // free is taken from the pre-edge level, so a same-cycle pop never makes room for a push
  assign push_bad = push_valid && (32'(push_nbytes) > WORD_BYTES || 32'(push_nbytes) > 32'(free));
  assign push_ok = !clr && push_valid && push_nbytes != '0 && !push_bad;
  assign pop = tx_valid && tx_ready;
  assign tx_valid = level != '0;
  assign empty = level == '0;
  assign full = level == (ADDR_W+1)'(DEPTH);
  assign push_ready = 32'(free) >= WORD_BYTES;
  assign tx_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++)
      if (push_ok && 32'(i) < 32'(push_nbytes)) mem[wr_ptr + ADDR_W'(i)] <= push_data[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (push_ok ? ADDR_W'(push_nbytes) : '0);
      rd_ptr <= rd_ptr + ADDR_W'(pop);
      level <= level + (push_ok ? (ADDR_W+1)'(push_nbytes) : '0) - (ADDR_W+1)'(pop);
      overflow <= overflow | push_bad;
    end
  end
endmodule

// File: tb/tb_tx_byte_fifo.sv
// tb_tx_byte_fifo: random and directed stimulus against a byte-queue reference model (DEPTH=8)
module tb_tx_byte_fifo;
  localparam int ADDR_W = 3;
  localparam int WB = 4;
  localparam int CNT_W = $clog2(WB + 1);
  localparam int DEPTH = 1 << ADDR_W;
  logic clk = 0, rstn = 0, flush = 0, push_valid = 0, tx_ready = 0;
  logic [CNT_W-1:0] push_nbytes = '0;
  logic [8*WB-1:0] push_data = '0;
  logic push_ready, tx_valid, empty, full, overflow;
  logic [7:0] tx_data;
  logic [ADDR_W:0] level;
  int n_chk = 0, n_pass = 0;
  bit check_on = 0;
  logic [7:0] q[$];
  bit m_ovf = 0;
  tx_byte_fifo #(.ADDR_W(ADDR_W), .WORD_BYTES(WB)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .push_valid(push_valid),
    .push_nbytes(push_nbytes), .push_data(push_data), .push_ready(push_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .level(level),
    .empty(empty), .full(full), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic check_outputs();
    int n = q.size();
    chk("level", 32'(level), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("tx_valid", 32'(tx_valid), 32'(n != 0));
    chk("push_ready", 32'(push_ready), 32'(DEPTH - n >= WB));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (n != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
  endtask
  task automatic cycle(input bit rn, input bit fl, input bit pv, input int nb, input logic [31:0] d, input bit tr);
    int free;
    @(negedge clk);
    if (check_on) check_outputs();
    rstn = rn; flush = fl; push_valid = pv; push_nbytes = CNT_W'(nb); push_data = d; tx_ready = tr;
    if (!rn || fl) begin
      q.delete();
      m_ovf = 0;
    end else begin
      free = DEPTH - q.size();
      if (pv && (nb > WB || nb > free)) m_ovf = 1;
      if (tr && q.size() != 0) void'(q.pop_front());
      if (pv && nb >= 1 && nb <= WB && nb <= free)
        for (int i = 0; i < nb; i++) q.push_back(d[8*i +: 8]);
    end
    @(posedge clk);
    check_on = 1;
  endtask
  initial begin
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 4, 32'h01020304, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 4, 32'h44332211, 0);
    cycle(1, 0, 1, 2, 32'hDEAD6655, 0);
    repeat (7) cycle(1, 0, 0, 0, 0, 1);
    cycle(1, 0, 1, 4, 32'hA3A2A1A0, 0);
    cycle(1, 0, 1, 4, 32'hB3B2B1B0, 0);
    cycle(1, 0, 1, 1, 32'h000000C0, 0);
    cycle(1, 0, 1, 2, 32'h0000D1D0, 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 3, 32'h00E2E1E0, 0);
    cycle(1, 0, 1, 2, 32'h0000F1F0, 1);
    cycle(1, 0, 1, 1, 32'h000000F2, 0);
    cycle(1, 0, 1, 7, 32'h12345678, 0);
    cycle(1, 1, 1, 4, 32'h99999999, 1);
    cycle(1, 0, 1, 1, 32'h000000AB, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(1, 0, 1, 4, $urandom, 1);
    repeat (10) cycle(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 7), $urandom, $urandom_range(0, 2) != 0);
    cycle(1, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tx_byte_fifo.md
Name: tx_byte_fifo

Overview:
- Parametrised transmit FIFO between the core's output path and the UART transmitter.
- Core pushes 1..WORD_BYTES bytes per cycle, packed little-end first; UART side pops one byte per ready/valid handshake.
- Adds pointer-managed wrap-around storage, occupancy/full/empty status, sticky overflow and synchronous flush.

Parameters:
- ADDR_W, 10, log2 of byte depth; DEPTH = 2**ADDR_W bytes.
- WORD_BYTES, 4, maximum bytes accepted per push cycle (1..8).
- CNT_W, $clog2(WORD_BYTES+1), width of push_nbytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  synchronous reset, active-low.
- flush  in  1  synchronous clear of FIFO contents and status.
- push_valid  in  1  push request this cycle.
- push_nbytes  in  CNT_W  number of valid bytes in push_data (0..WORD_BYTES).
- push_data  in  8*WORD_BYTES  bytes; [7:0] is sent first, then [15:8], and so on.
- push_ready  out  1  high when free space >= WORD_BYTES (advisory).
- tx_valid  out  1  a byte is available for the UART.
- tx_data  out  8  byte at the read pointer.
- tx_ready  in  1  UART takes tx_data this cycle when tx_valid is also high.
- level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; a push was rejected for lack of space.

Behaviour:
- Reset: rstn low at an edge sets wr_ptr=0, rd_ptr=0, level=0, overflow=0.
  - Resulting outputs: tx_valid=0, empty=1, full=0, push_ready=1.
  - Storage contents are not cleared.
  - Reset overrides any push, pop or flush in the same cycle.
- Flush: rstn high and flush high has the same effect as reset. It takes priority over push and pop in that cycle; neither is performed.
- free = DEPTH - level, using level before this edge. A same-cycle pop gives no credit to a push.
- Push accepted when push_valid=1, 1 <= push_nbytes <= WORD_BYTES, and push_nbytes <= free.
  - Byte i is written to mem[(wr_ptr+i) mod DEPTH] for i < push_nbytes.
  - wr_ptr advances by push_nbytes, modulo DEPTH.
- Push rejected, with nothing written, when push_valid=1 and push_nbytes > free, or push_nbytes > WORD_BYTES. A rejection sets overflow=1 on that edge. Partial writes never occur.
- push_valid=1 with push_nbytes=0 is a no-op, not an error.
- Pop occurs when tx_valid && tx_ready. rd_ptr advances by 1, modulo DEPTH.
- tx_valid = (level != 0). tx_data = mem[rd_ptr] is an asynchronous read. tx_data is don't-care while tx_valid=0.
- Latency: bytes pushed at edge N are visible on tx_valid/tx_data after edge N. There is no write-to-read bypass inside a cycle.
- level(next) = level + accepted_nbytes - pop. Push and pop in the same cycle are both performed.
- Pointers are ADDR_W bits and wrap naturally. level, not pointer comparison, distinguishes full from empty.
- push_ready, empty, full and tx_valid are combinational from level. overflow is registered.
- Storage is inferred as distributed or block RAM (one multi-byte write port, one read port). Implement it as a byte array indexed modulo DEPTH.

Test Plan:
- Reset/idle: hold rstn=0 for 2 cycles, then release -> level=0, empty=1, tx_valid=0, push_ready=1, overflow=0.
- Ordered multi-byte push: push nbytes=4, data=0x44332211; then nbytes=2, data=0x....6655 -> level=6; draining with tx_ready=1 yields 11,22,33,44,55,66; empty=1 after the 6th pop.
- Wrap-around: ADDR_W=3 (DEPTH=8); push 4x4 bytes while popping steadily -> wr_ptr wraps 7->0; byte order is preserved across the wrap; level never exceeds 8.
- Full/overflow: DEPTH=8, push 4+4 -> full=1, push_ready=0; then push nbytes=1 -> rejected, level stays 8, overflow=1. Next, pop 1 and push 2 in the same cycle -> push rejected (free=0 before the edge), level=7.
- Simultaneous push/pop at level=3: push 2 bytes and pop 1 -> level=4 next cycle; popped byte is the oldest.
- Flush mid-stream: level=5, overflow=1, then flush=1 with push_valid=1 and tx_ready=1 -> level=0, overflow=0, nothing written or popped; the next push of 0xAB appears as tx_data=AB the following cycle.
